// File: rtl/eeprom_seq.sv
// eeprom_seq: command-level sequencer feeding the at24c02_ctl parent port.
// Splits {addr, len, dir} commands into page-aligned segments, buffers one
// page of write or read data, and waits out the EEPROM write cycle between
// write segments. Optional macro EEPROM_SEQ_VERIFY_EN adds a read-back of
// each written segment that sets the sticky verify_err flag on mismatch.
module eeprom_seq #(
  parameter int ADDR_W    = 11,
  parameter int PAGE_SIZE = 16,
  parameter int LEN_W     = 9,
  parameter int WR_CYCLES = 250000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              cmd_wr,
  input  logic [7:0]        wdata,
  input  logic              wdata_valid,
  output logic              wdata_ready,
  output logic [7:0]        rdata,
  output logic              rdata_valid,
  input  logic              rdata_ready,
  output logic              busy,
  output logic              done,
  output logic              verify_err,
  output logic [ADDR_W-1:0] ctl_address,
  output logic [7:0]        ctl_din,
  input  logic [7:0]        ctl_dout,
  output logic              ctl_wr_en,
  output logic              ctl_parent_ready,
  output logic              ctl_last,
  input  logic              ctl_ready
);

  localparam int PB    = $clog2(PAGE_SIZE);
  localparam int CNT_W = (WR_CYCLES > 1) ? $clog2(WR_CYCLES) : 1;

  typedef enum logic [2:0] {
    IDLE, FILL, XFER_W, WAIT_WR, XFER_R, DRAIN, VRFY, FIN
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [LEN_W-1:0]  rem;
  logic [LEN_W-1:0]  seg;
  logic [LEN_W-1:0]  idx;
  logic [CNT_W-1:0]  cnt;
  logic [7:0]        mem [PAGE_SIZE];

  logic [LEN_W-1:0]  idx_nx;
  logic [PB-1:0]     idx_lo;
  logic [PB-1:0]     nx_lo;
  logic              last_byte;
  logic [ADDR_W-1:0] addr_nx;
  logic [LEN_W-1:0]  rem_nx;
  logic [LEN_W-1:0]  seg_nx;

  // Bytes left in the current page, capped by the bytes left in the command.
  function automatic logic [LEN_W-1:0] calc_seg(input logic [ADDR_W-1:0] a,
                                                input logic [LEN_W-1:0]  r);
    logic [LEN_W-1:0] room;
    room = LEN_W'(PAGE_SIZE) - LEN_W'(a[PB-1:0]);
    return (r < room) ? r : room;
  endfunction

  assign idx_nx    = idx + LEN_W'(1);
  assign idx_lo    = idx[PB-1:0];
  assign nx_lo     = idx_nx[PB-1:0];
  assign last_byte = (idx == seg - LEN_W'(1));
  assign addr_nx   = addr + ADDR_W'(seg);
  assign rem_nx    = rem - seg;
  assign seg_nx    = calc_seg(addr_nx, rem_nx);

`ifdef EEPROM_SEQ_VERIFY_EN
  logic verr;
  assign verify_err = verr;
`else
  assign verify_err = 1'b0;
`endif

  // Page buffer: filled from wdata in FILL, from ctl_dout in XFER_R (no reset).
  always_ff @(posedge clk) begin
    if (state == FILL && wdata_valid && wdata_ready)
      mem[idx_lo] <= wdata;
    else if (state == XFER_R && ctl_parent_ready && ctl_ready)
      mem[idx_lo] <= ctl_dout;
  end

  // Command sequencer FSM with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      cmd_ready        <= 1'b1;
      busy             <= 1'b0;
      done             <= 1'b0;
      wdata_ready      <= 1'b0;
      rdata            <= '0;
      rdata_valid      <= 1'b0;
      ctl_address      <= '0;
      ctl_din          <= '0;
      ctl_wr_en        <= 1'b0;
      ctl_parent_ready <= 1'b0;
      ctl_last         <= 1'b0;
      addr             <= '0;
      rem              <= '0;
      seg              <= '0;
      idx              <= '0;
      cnt              <= '0;
`ifdef EEPROM_SEQ_VERIFY_EN
      verr             <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            addr      <= cmd_addr;
            rem       <= cmd_len;
            seg       <= calc_seg(cmd_addr, cmd_len);
            idx       <= '0;
`ifdef EEPROM_SEQ_VERIFY_EN
            verr      <= 1'b0;
`endif
            if (cmd_len == '0) begin
              state <= FIN;
              done  <= 1'b1;
            end else if (cmd_wr) begin
              state       <= FILL;
              wdata_ready <= 1'b1;
            end else begin
              state <= XFER_R;
            end
          end
        end
        FILL: begin
          if (wdata_valid && wdata_ready) begin
            if (last_byte) begin
              wdata_ready <= 1'b0;
              idx         <= '0;
              state       <= XFER_W;
            end else begin
              idx <= idx_nx;
            end
          end
        end
        // Parent handshake is raised one cycle after entry and held for the
        // whole segment; ctl_ready is only honoured while it is high.
        XFER_W, XFER_R, VRFY: begin
          if (!ctl_parent_ready) begin
            ctl_parent_ready <= 1'b1;
            ctl_address      <= addr;
            ctl_wr_en        <= (state == XFER_W);
            ctl_din          <= (state == XFER_W) ? mem[0] : 8'h00;
            ctl_last         <= (seg == LEN_W'(1));
            idx              <= '0;
          end else if (ctl_ready) begin
`ifdef EEPROM_SEQ_VERIFY_EN
            if (state == VRFY && ctl_dout != mem[idx_lo])
              verr <= 1'b1;
`endif
            if (last_byte) begin
              ctl_parent_ready <= 1'b0;
              ctl_last         <= 1'b0;
              idx              <= '0;
              if (state == XFER_W) begin
                state <= WAIT_WR;
                cnt   <= '0;
              end else if (state == XFER_R) begin
                state <= DRAIN;
              end else begin
                addr <= addr_nx;
                rem  <= rem_nx;
                seg  <= seg_nx;
                if (rem_nx == '0) begin
                  state <= FIN;
                  done  <= 1'b1;
                end else begin
                  state       <= FILL;
                  wdata_ready <= 1'b1;
                end
              end
            end else begin
              idx      <= idx_nx;
              ctl_din  <= (state == XFER_W) ? mem[nx_lo] : 8'h00;
              ctl_last <= (idx_nx == seg - LEN_W'(1));
            end
          end
        end
        WAIT_WR: begin
          if (cnt == CNT_W'(WR_CYCLES - 1)) begin
`ifdef EEPROM_SEQ_VERIFY_EN
            state <= VRFY;
`else
            addr <= addr_nx;
            rem  <= rem_nx;
            seg  <= seg_nx;
            if (rem_nx == '0) begin
              state <= FIN;
              done  <= 1'b1;
            end else begin
              state       <= FILL;
              wdata_ready <= 1'b1;
            end
`endif
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DRAIN: begin
          if (!rdata_valid) begin
            rdata       <= mem[idx_lo];
            rdata_valid <= 1'b1;
          end else if (rdata_ready) begin
            if (last_byte) begin
              rdata_valid <= 1'b0;
              idx         <= '0;
              addr        <= addr_nx;
              rem         <= rem_nx;
              seg         <= seg_nx;
              if (rem_nx == '0) begin
                state <= FIN;
                done  <= 1'b1;
              end else begin
                state <= XFER_R;
              end
            end else begin
              idx   <= idx_nx;
              rdata <= mem[nx_lo];
            end
          end
        end
        FIN: begin
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eeprom_seq.sv
// tb_eeprom_seq: randomized bench for eeprom_seq with an at24c02_ctl-style
// byte-pulse model, a reference memory and per-command segment arithmetic.
module tb_eeprom_seq;

  localparam int ADDR_W    = 11;
  localparam int PAGE_SIZE = 16;
  localparam int LEN_W     = 9;
  localparam int WR_CYCLES = 30;
  localparam int AMASK     = (1 << ADDR_W) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              cmd_valid, cmd_ready, cmd_wr;
  logic [ADDR_W-1:0] cmd_addr;
  logic [LEN_W-1:0]  cmd_len;
  logic [7:0]        wdata, rdata, ctl_din, ctl_dout;
  logic              wdata_valid, wdata_ready, rdata_valid, rdata_ready;
  logic              busy, done, verify_err;
  logic [ADDR_W-1:0] ctl_address;
  logic              ctl_wr_en, ctl_parent_ready, ctl_last, ctl_ready;

  eeprom_seq #(.ADDR_W(ADDR_W), .PAGE_SIZE(PAGE_SIZE), .LEN_W(LEN_W),
               .WR_CYCLES(WR_CYCLES)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len), .cmd_wr(cmd_wr),
    .wdata(wdata), .wdata_valid(wdata_valid), .wdata_ready(wdata_ready),
    .rdata(rdata), .rdata_valid(rdata_valid), .rdata_ready(rdata_ready),
    .busy(busy), .done(done), .verify_err(verify_err),
    .ctl_address(ctl_address), .ctl_din(ctl_din), .ctl_dout(ctl_dout),
    .ctl_wr_en(ctl_wr_en), .ctl_parent_ready(ctl_parent_ready),
    .ctl_last(ctl_last), .ctl_ready(ctl_ready)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] out_vec();
    return 64'({cmd_ready, wdata_ready, rdata, rdata_valid, busy, done, verify_err,
                ctl_address, ctl_din, ctl_wr_en, ctl_parent_ready, ctl_last});
  endfunction
  localparam logic [63:0] RESET_VEC = 64'h8_0000_0000;

  // Memories: ee is what the EEPROM model holds, ref_mem is what commands intended.
  logic [7:0] ee      [2048];
  logic [7:0] ref_mem [2048];

  typedef struct { int a; logic [7:0] d; bit last; bit wr; } pulse_t;
  pulse_t plog[$];
  int sg_a[$], sg_n[$], sg_w[$];
  int last_wr_end = 0;
  bit gap_armed   = 0;
  bit corrupt_arm = 0;
  int pr_cnt      = 0;

  // at24c02_ctl stand-in: random latency, one ctl_ready pulse per byte,
  // stops pulsing after the byte flagged ctl_last until the request drops.
  initial begin
    int off, dly, a, cur_a, cur_n;
    bit wait_drop, prev_pr, cur_w;
    pulse_t p;
    off = 0; dly = 1; wait_drop = 0; prev_pr = 0; cur_a = 0; cur_n = 0; cur_w = 0;
    ctl_ready = 1'b0; ctl_dout = 8'h00;
    forever begin
      @(negedge clk);
      ctl_ready = 1'b0;
      if (prev_pr && !ctl_parent_ready && !rst) begin
        sg_a.push_back(cur_a); sg_n.push_back(cur_n); sg_w.push_back(int'(cur_w));
      end
      if (rst || !ctl_parent_ready) begin
        off = 0; wait_drop = 0; dly = $urandom_range(1, 4);
      end else begin
        pr_cnt++;
        if (!prev_pr) begin
          if (gap_armed) chk("wr_gap", 64'(cyc - last_wr_end >= WR_CYCLES), 64'd1);
          cur_a = int'(ctl_address); cur_n = 0; cur_w = ctl_wr_en;
        end
        if (!wait_drop) begin
          if (dly > 0) dly--;
          else begin
            a = (int'(ctl_address) + off) & AMASK;
            ctl_ready = 1'b1;
            cur_n++;
            if (ctl_wr_en) begin
              ee[a] = ctl_din;
              if (ctl_last) begin
                last_wr_end = cyc; gap_armed = 1;
                if (corrupt_arm) begin ee[a] = ee[a] ^ 8'h01; corrupt_arm = 0; end
              end
            end else ctl_dout = ee[a];
            p.a = a; p.d = ctl_wr_en ? ctl_din : ee[a]; p.last = ctl_last; p.wr = ctl_wr_en;
            plog.push_back(p);
            if (ctl_last) wait_drop = 1;
            off++;
            dly = $urandom_range(0, 3);
          end
        end
      end
      prev_pr = ctl_parent_ready && !rst;
    end
  end

  // Write-data source with random valid gaps.
  logic [7:0] wq[$];
  initial begin
    bit pv, prd;
    pv = 0; prd = 0; wdata_valid = 1'b0; wdata = 8'h00;
    forever begin
      @(negedge clk);
      if (rst) begin
        wq.delete(); wdata_valid = 1'b0; pv = 0; prd = 0;
      end else begin
        if (pv && prd && wq.size() > 0) void'(wq.pop_front());
        if (wq.size() > 0 && $urandom_range(0, 3) != 0) begin
          wdata = wq[0]; wdata_valid = 1'b1;
        end else wdata_valid = 1'b0;
        pv = wdata_valid; prd = wdata_ready;
      end
    end
  end

  // Read-data sink with random back-pressure, optional long stall, hold check.
  logic [7:0] rq[$];
  int stall_at = 0, stall_left = 0, stall_pr = 0, hold_err = 0;
  initial begin
    bit pv, prr;
    logic [7:0] pd;
    pv = 0; prr = 0; pd = 8'h00; rdata_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        rdata_ready = 1'b0; pv = 0; prr = 0;
      end else begin
        if (pv && prr) rq.push_back(pd);
        if (pv && !prr && (!rdata_valid || rdata !== pd)) hold_err++;
        if (stall_left > 0 && rq.size() >= stall_at) begin
          rdata_ready = 1'b0; stall_left--;
          if (ctl_parent_ready) stall_pr++;
        end else rdata_ready = ($urandom_range(0, 3) != 0);
        pv = rdata_valid; pd = rdata; prr = rdata_ready;
      end
    end
  end

  int done_cnt = 0, busy_cnt = 0;
  initial forever begin
    @(negedge clk);
    if (done) done_cnt++;
    if (busy) busy_cnt++;
  end

  bit exp_verr = 0;

  // One command end to end, checked against page arithmetic and ref_mem.
  task automatic run_cmd(input int addr, input int len, input bit wr, input string nm);
    int a, r, s, t, nseg;
    int ea[$], en[$], fa[$], fl[$];
    logic [7:0] dat[$], fd[$];
    bit el;
    a = addr; r = len;
    while (r > 0) begin
      s = PAGE_SIZE - (a % PAGE_SIZE);
      if (r < s) s = r;
      ea.push_back(a); en.push_back(s);
      a = (a + s) & AMASK; r -= s;
    end
    for (int k = 0; k < len; k++)
      dat.push_back(wr ? 8'($urandom) : ref_mem[(addr + k) & AMASK]);
    plog.delete(); sg_a.delete(); sg_n.delete(); sg_w.delete(); rq.delete();
    if (wr) foreach (dat[k]) wq.push_back(dat[k]);
    t = 0;
    while (!cmd_ready && t < 100) begin @(negedge clk); t++; end
    chk({nm, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
    done_cnt = 0; busy_cnt = 0; pr_cnt = 0;
    cmd_addr = addr[ADDR_W-1:0]; cmd_len = len[LEN_W-1:0]; cmd_wr = wr; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    if (len == 0) chk({nm, "_done_next"}, 64'(done), 64'd1);
    t = 0;
    while (done_cnt == 0 && t < 20000) begin @(negedge clk); t++; end
    chk({nm, "_done_seen"}, 64'(done_cnt > 0), 64'd1);
    repeat (3) @(negedge clk);
    chk({nm, "_done_once"}, 64'(done_cnt), 64'd1);
    chk({nm, "_verr"}, 64'(verify_err), 64'(exp_verr));
    if (len == 0) begin
      chk({nm, "_busy_1cyc"}, 64'(busy_cnt), 64'd1);
      chk({nm, "_no_ctl"}, 64'(pr_cnt), 64'd0);
    end
    nseg = 0;
    foreach (sg_a[i]) if (sg_w[i] == int'(wr)) begin
      if (nseg < ea.size()) begin
        chk({nm, "_seg_addr"}, 64'(sg_a[i]), 64'(ea[nseg]));
        chk({nm, "_seg_len"}, 64'(sg_n[i]), 64'(en[nseg]));
      end
      nseg++;
    end
    chk({nm, "_nseg"}, 64'(nseg), 64'(ea.size()));
    foreach (plog[i]) if (plog[i].wr == wr) begin
      fa.push_back(plog[i].a); fl.push_back(int'(plog[i].last)); fd.push_back(plog[i].d);
    end
    chk({nm, "_nbytes"}, 64'(fa.size()), 64'(len));
    for (int k = 0; k < len && k < fa.size(); k++) begin
      el = (((addr + k + 1) % PAGE_SIZE) == 0) || (k == len - 1);
      chk({nm, "_baddr"}, 64'(fa[k]), 64'((addr + k) & AMASK));
      chk({nm, "_blast"}, 64'(fl[k]), 64'(el));
      if (wr) chk({nm, "_wbyte"}, 64'(fd[k]), 64'(dat[k]));
    end
    if (!wr) begin
      chk({nm, "_nrd"}, 64'(rq.size()), 64'(len));
      for (int k = 0; k < len && k < rq.size(); k++)
        chk({nm, "_rbyte"}, 64'(rq[k]), 64'(dat[k]));
    end else begin
      for (int k = 0; k < len; k++) ref_mem[(addr + k) & AMASK] = dat[k];
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    rst = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0; cmd_wr = 1'b0;
    for (int i = 0; i < 2048; i++) begin
      ee[i] = 8'($urandom); ref_mem[i] = ee[i];
    end
    repeat (3) @(negedge clk);
    chk("reset_outs", out_vec(), RESET_VEC);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_outs", out_vec(), RESET_VEC);

    run_cmd(11'h123, 16, 1'b1, "w123");
    run_cmd(11'h123, 16, 1'b0, "r123");
    run_cmd(11'h7FE, 4, 1'b1, "wwrap");
    run_cmd(0, 0, 1'b1, "len0");

    rq.delete(); stall_at = 2; stall_left = 50; stall_pr = 0;
    run_cmd(11'h7FC, 8, 1'b0, "rstall");
    chk("stall_done", 64'(stall_left), 64'd0);
    chk("stall_no_seg", 64'(stall_pr), 64'd0);

    // Reset in the middle of a write segment.
    plog.delete();
    for (int k = 0; k < 10; k++) wq.push_back(8'($urandom));
    cmd_addr = 11'h040; cmd_len = 9'd10; cmd_wr = 1'b1; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    t = 0;
    while (plog.size() < 5 && t < 5000) begin @(negedge clk); t++; end
    chk("rst_reach_b5", 64'(plog.size() >= 5), 64'd1);
    rst = 1'b1;
    #1;
    chk("rst_async_outs", out_vec(), RESET_VEC);
    @(negedge clk);
    wq.delete();
    @(negedge clk);
    rst = 1'b0;
    foreach (plog[i]) if (plog[i].wr) ref_mem[plog[i].a] = plog[i].d;
    run_cmd(11'h123, 16, 1'b0, "r_after_rst");

    for (int i = 0; i < 6; i++)
      run_cmd(int'($urandom_range(0, 2047)), int'($urandom_range(1, 40)),
              1'($urandom_range(0, 1)), "rnd");

`ifdef EEPROM_SEQ_VERIFY_EN
    corrupt_arm = 1; exp_verr = 1;
    run_cmd(11'h300, 16, 1'b1, "vfy_bad");
    exp_verr = 0;
    run_cmd(11'h123, 4, 1'b0, "vfy_clr");
`endif

    chk("rdata_hold", 64'(hold_err), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/eeprom_seq.md
Name: eeprom_seq

Overview:
Command-level sequencer sitting directly upstream of at24c02_ctl; it drives that controller's parent interface. It accepts one command (start address, byte count, direction) and splits it into page-aligned segments, so that write bursts never cross an EEPROM page. Write data and read data each pass through a one-page buffer with valid/ready streams. Between write segments it enforces the EEPROM internal write-cycle time.

Parameters:
ADDR_W, 11, EEPROM byte-address width; addresses wrap modulo 2**ADDR_W.
PAGE_SIZE, 16, page size in bytes; power of two, maximum 256.
LEN_W, 9, command length width; legal lengths are 0..256.
WR_CYCLES, 250000, clk cycles to wait after a write segment's last byte (5 ms at 50 MHz).

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
cmd_valid  in  1  command offered
cmd_ready  out  1  high only in IDLE
cmd_addr  in  ADDR_W  start byte address
cmd_len  in  LEN_W  byte count
cmd_wr  in  1  1 = write, 0 = read
wdata  in  8  write byte stream
wdata_valid  in  1  write byte valid
wdata_ready  out  1  sequencer accepts write byte
rdata  out  8  read byte stream
rdata_valid  out  1  read byte valid
rdata_ready  in  1  consumer accepts read byte
busy  out  1  command in progress
done  out  1  one-cycle pulse when a command completes
verify_err  out  1  sticky mismatch flag (see Optional Feature)
ctl_address  out  ADDR_W  segment start address to at24c02_ctl
ctl_din  out  8  write byte to at24c02_ctl
ctl_dout  in  8  read byte from at24c02_ctl
ctl_wr_en  out  1  segment direction
ctl_parent_ready  out  1  request/hold a transaction
ctl_last  out  1  current byte is the segment's final byte
ctl_ready  in  1  one-cycle pulse: byte transferred (ctl_din consumed / ctl_dout valid)

Behaviour:
- Reset values: all outputs 0, except cmd_ready, which is 1 (IDLE). Buffer contents are don't-care.
- Command acceptance: the command is taken on cmd_valid && cmd_ready, and addr, len and wr are latched.
  - len = 0: done pulses on the next cycle; no ctl traffic.
- Segment length: seg = min(remaining, PAGE_SIZE - (addr % PAGE_SIZE)).
  - After each segment: addr += seg (wrap mod 2**ADDR_W); remaining -= seg.
- States: IDLE, FILL, XFER_W, WAIT_WR, XFER_R, DRAIN, FIN.
  - IDLE: on cmd_wr = 1 go to FILL; otherwise go to XFER_R.
  - FILL: wdata_ready = 1 until seg bytes are buffered (index 0..seg-1), then go to XFER_W.
  - XFER_W:
    - ctl_address = addr, ctl_wr_en = 1, ctl_parent_ready = 1 throughout.
    - ctl_din = buf[idx]; ctl_last = (idx == seg-1).
    - On each ctl_ready pulse: idx++. On the pulse for the last byte, drop ctl_parent_ready and ctl_last the following cycle and go to WAIT_WR.
  - WAIT_WR: count WR_CYCLES, then go to FILL if remaining > 0, else FIN.
  - XFER_R: same as XFER_W but ctl_wr_en = 0. On each ctl_ready, buf[idx] <= ctl_dout. After the last byte go to DRAIN.
  - DRAIN: present buf[0..seg-1] on rdata; advance on rdata_valid && rdata_ready. When empty, go to XFER_R if remaining > 0, else FIN.
  - FIN: done = 1 for one cycle, then IDLE.
- Timing and flow control:
  - ctl_parent_ready never deasserts mid-segment. Back-pressure applies only in FILL and DRAIN.
  - rdata and rdata_valid hold stable while rdata_ready is low.
- Timing properties: busy = !IDLE. First ctl_parent_ready rises ≥ 1 cycle after the segment is fully buffered. A ctl_ready received outside XFER_* is ignored.
- Reset mid-operation: state returns to IDLE immediately and ctl_parent_ready drops asynchronously. at24c02_ctl shares rst, so the bus transaction is abandoned. A partially written page is not recovered.

Optional Feature:
EEPROM_SEQ_VERIFY_EN
- Defined: after WAIT_WR, the same segment is read back (ctl_wr_en = 0, same address and length). Each ctl_dout is compared with buf[idx]; any mismatch sets verify_err. verify_err clears only on reset or on acceptance of a new command. Read-back bytes are not emitted on rdata.
- Undefined: no read-back, verify_err tied 0, WAIT_WR proceeds directly to FILL or FIN.

Test Plan:
- Write 0x123, len 16, bytes 0x50..0x5F:
  - Two segments: 13 bytes at 0x123 (ctl_last on byte 0x5C), then 3 bytes at 0x130 (ctl_last on 0x5F).
  - Gap of ≥ WR_CYCLES between them; done pulses once.
- Read 0x123, len 16 (after the previous write, with at24c02 model attached): rdata sequence = 0x50..0x5F, segments 13 + 3.
- Write 0x7FE, len 4: segments at 0x7FE (2 bytes) and 0x000 (2 bytes); address wraps.
- len 0 command: done pulses 1 cycle after acceptance; ctl_parent_ready stays 0; busy high for exactly 1 cycle.
- Read len 8 with rdata_ready low for 50 cycles mid-drain: rdata holds, no byte is lost or duplicated, and the next segment does not start until the drain is complete.
- Assert rst during XFER_W byte 5: all outputs return to reset values in the same cycle. A following read command works normally.
- (With EEPROM_SEQ_VERIFY_EN) corrupt one model byte before read-back: verify_err = 1 after the segment, and it clears on the next cmd acceptance.
